// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one 1-bit cell.
// Latency is WIDTH+2 cycles from start acceptance to the next possible start.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   start   request, sampled only while idle
//   A       minuend, captured when start is accepted
//   B       subtrahend, captured when start is accepted
//   bin     borrow-in, captured when start is accepted
//   busy    high while bits are being processed
//   done    single-cycle completion pulse
//   Diff    (A - B - bin) mod 2^WIDTH, held until the next completion
//   Borrow  final borrow-out, held with Diff

// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_dataflow (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic load_c, step_c, last_c;
    logic d_c, b_c;
    logic [WIDTH-1:0] res_nxt_c;

    full_subtractor_dataflow u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_c),
        .bout (b_c)
    );

    // Result bits enter at the MSB and walk down, so after WIDTH steps bit 0 is the LSB.
    assign res_nxt_c = {d_c, res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done track the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Borrow <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state_nxt == DONE);
            if (load_c) begin
                a_sr <= A;
                b_sr <= B;
                br   <= bin;
                cnt  <= '0;
            end else if (step_c) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                res  <= res_nxt_c;
                br   <= b_c;
                // Stop counting on the last bit so cnt never passes WIDTH-1.
                if (!last_c) cnt <= cnt + CNT_W'(1);
            end
            if (last_c) begin
                Diff   <= res_nxt_c;
                Borrow <= b_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int W  = 8;
    localparam int W4 = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, bin, busy, done, borrow;
    logic [W-1:0] a, b, diff;
    logic          start4, bin4, busy4, done4, borrow4;
    logic [W4-1:0] a4, b4, diff4;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] hold_d;
    logic         hold_b;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[10];
    vec_t stream[3];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .bin(bin),
        .busy(busy), .done(done), .Diff(diff), .Borrow(borrow)
    );

    serial_subtractor #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .bin(bin4),
        .busy(busy4), .done(done4), .Diff(diff4), .Borrow(borrow4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One 8-bit operation; cycle c is observed at the negedge opening it, then driven.
    // Operand inputs are scrambled after capture; optional start probe in cycle 4.
    task automatic op8(input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                       input logic [7:0] ed, input logic eb, input bit probe);
        for (int c = 0; c <= W + 4; c++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(c >= 1 && c <= W));
            chk("done", 32'(done), 32'(c == W + 1));
            if (c <= W) begin
                chk("diff_held", 32'(diff), 32'(hold_d));
                chk("borrow_held", 32'(borrow), 32'(hold_b));
            end else begin
                chk("diff", 32'(diff), 32'(ed));
                chk("borrow", 32'(borrow), 32'(eb));
            end
            if (c == 0) begin
                start = 1'b1; a = oa; b = ob; bin = obin;
            end else if (probe && c == 4) begin
                start = 1'b1; a = 8'h00; b = 8'hFF; bin = 1'b0;
            end else begin
                start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
        end
        hold_d = ed;
        hold_b = eb;
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};
        stream[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        stream[1] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1};
        stream[2] = '{8'hAB, 8'h0B, 1'b0, 8'hA0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        hold_d = '0; hold_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_w4_diff", 32'(diff4), 32'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 10; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, 1'b0);

        // start while busy is ignored and not queued
        op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);

        // start held high: acceptance every W+2 cycles
        for (int c = 0; c < 3 * (W + 2); c++) begin
            int k, r;
            k = c / (W + 2);
            r = c % (W + 2);
            @(negedge clk);
            chk("stream_busy", 32'(busy), 32'(r >= 1 && r <= W));
            chk("stream_done", 32'(done), 32'(r == W + 1));
            if (r == W + 1) begin
                chk("stream_diff", 32'(diff), 32'(stream[k].d));
                chk("stream_borrow", 32'(borrow), 32'(stream[k].bo));
            end
            start = (c != 3 * (W + 2) - 1);
            if (r == 0) begin
                a = stream[k].a; b = stream[k].b; bin = stream[k].bin;
            end else begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
        end
        hold_d = stream[2].d;
        hold_b = stream[2].bo;

        // Mid-operation reset aborts with no done pulse
        for (int c = 0; c <= W + 4; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                chk("abort_busy_pre", 32'(busy), 32'd1);
            end else if (c >= 5) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_diff", 32'(diff), 32'd0);
                chk("abort_borrow", 32'(borrow), 32'd0);
            end
            start = (c == 0);
            a = 8'h33; b = 8'h11; bin = 1'b0;
            rst = (c == 4);
        end
        hold_d = '0;
        hold_b = 1'b0;
        op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

        // WIDTH=4 exhaustive against the arithmetic rule
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [4:0] exp5;
                    exp5 = 5'(ia) - 5'(ib) - 5'(ic);
                    for (int c = 0; c <= W4 + 1; c++) begin
                        @(negedge clk);
                        chk("w4_done", 32'(done4), 32'(c == W4 + 1));
                        if (c == W4 + 1) begin
                            chk("w4_diff", 32'(diff4), 32'(exp5[3:0]));
                            chk("w4_borrow", 32'(borrow4), 32'(exp5[4]));
                        end
                        start4 = (c == 0);
                        a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic);
                    end
                end
            end
        end
        start4 = 1'b0;
        @(negedge clk);
        chk("w4_idle_done", 32'(done4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
